// File: rtl/cpu_state_fsm_if.sv
// cpu_state_fsm_if: control-side bundle for the multicycle CPU state machine.
// master drives the stall and opcode; slave (the FSM) returns state, flag and count.
interface cpu_state_fsm_if #(
    parameter int unsigned CNT_W = 16
);
    logic             pause;
    logic [5:0]       opcode;
    logic [3:0]       current_state;
    logic             illegal;
    logic [CNT_W-1:0] inst_count;

    modport master (
        output pause,
        output opcode,
        input  current_state,
        input  illegal,
        input  inst_count
    );

    modport slave (
        input  pause,
        input  opcode,
        output current_state,
        output illegal,
        output inst_count
    );
endinterface

// File: rtl/cpu_state_fsm.sv
// cpu_state_fsm: multicycle CPU control state machine with a retired-instruction counter.
// Optional feature: define ILLEGAL_TRAP_EN to trap unsupported opcodes into HALT with
// illegal=1 until reset; otherwise such opcodes drop back to FETCH uncounted.
module cpu_state_fsm #(
    parameter int unsigned CNT_W = 16
) (
    input logic           clk,
    input logic           rst,
    cpu_state_fsm_if.slave bus
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StRex    = 4'd6,
        StRwb    = 4'd7,
        StBeq    = 4'd8,
        StJump   = 4'd9,
        StImmWb  = 4'd10,
        StLuiEx  = 4'd11,
        StLogEx  = 4'd12,
        StHalt   = 4'd13
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_d;
    logic [5:0]       r_op;
    logic [5:0]       w_op_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_retire;
`ifdef ILLEGAL_TRAP_EN
    logic             r_illegal;
    logic             w_illegal_d;
`endif

    // State, latched opcode, counter and trap flag; async clear on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StFetch;
            r_op      <= 6'd0;
            r_cnt     <= '0;
`ifdef ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_d;
            r_op      <= w_op_d;
            r_cnt     <= w_cnt_d;
`ifdef ILLEGAL_TRAP_EN
            r_illegal <= w_illegal_d;
`endif
        end
    end

    // Next-state decode; everything holds while paused. DECODE branches on the live
    // opcode, later states branch on the latched copy.
    always_comb begin
        w_state_d   = r_state;
        w_op_d      = r_op;
        w_retire    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        w_illegal_d = r_illegal;
`endif
        if (!bus.pause) begin
            case (r_state)
                StFetch: w_state_d = StDecode;
                StDecode: begin
                    w_op_d = bus.opcode;
                    case (bus.opcode)
                        OP_LW, OP_SW, OP_ADDI: w_state_d = StMemAdr;
                        OP_RTYP:               w_state_d = StRex;
                        OP_BEQ:                w_state_d = StBeq;
                        OP_J:                  w_state_d = StJump;
                        OP_LUI:                w_state_d = StLuiEx;
                        OP_ANDI, OP_ORI:       w_state_d = StLogEx;
                        default: begin
`ifdef ILLEGAL_TRAP_EN
                            w_state_d   = StHalt;
                            w_illegal_d = 1'b1;
`else
                            w_state_d   = StFetch;
`endif
                        end
                    endcase
                end
                StMemAdr: begin
                    case (r_op)
                        OP_LW:   w_state_d = StMemRd;
                        OP_SW:   w_state_d = StMemWr;
                        OP_ADDI: w_state_d = StImmWb;
                        default: w_state_d = StFetch;
                    endcase
                end
                StMemRd:          w_state_d = StMemWb;
                StRex:            w_state_d = StRwb;
                StLuiEx, StLogEx: w_state_d = StImmWb;
                StMemWb, StMemWr, StRwb, StImmWb, StBeq, StJump: begin
                    w_state_d = StFetch;
                    w_retire  = 1'b1;
                end
`ifdef ILLEGAL_TRAP_EN
                StHalt:           w_state_d = StHalt;
`else
                StHalt:           w_state_d = StFetch;
`endif
                default:          w_state_d = StFetch;
            endcase
        end
    end

    // Counter wraps silently at all-ones.
    always_comb begin
        w_cnt_d = r_cnt;
        if (w_retire) w_cnt_d = r_cnt + CNT_ONE;
    end

    assign bus.current_state = r_state;
    assign bus.inst_count    = r_cnt;
`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal       = r_illegal;
`else
    assign bus.illegal       = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_state_fsm.sv
// tb_cpu_state_fsm: directed bench for cpu_state_fsm with a 4-bit counter so wrap is reachable.
// Expectations follow ILLEGAL_TRAP_EN when it is defined for the bench as well.
module tb_cpu_state_fsm;

    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_cnt = 0;

    cpu_state_fsm_if #(.CNT_W(CW)) bus ();

    cpu_state_fsm #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    // Runs one instruction from FETCH and checks each state plus the retire count.
    task automatic run_instr(input string tag, input logic [5:0] op, input int len,
                             input logic [3:0] s2, input logic [3:0] s3,
                             input logic [3:0] s4);
        bus.opcode = op;
        chk({tag, ":fetch"}, 32'(bus.current_state), 0);
        tick();
        chk({tag, ":decode"}, 32'(bus.current_state), 1);
        tick();
        chk({tag, ":s2"}, 32'(bus.current_state), 32'(s2));
        if (len >= 4) begin
            tick();
            chk({tag, ":s3"}, 32'(bus.current_state), 32'(s3));
        end
        if (len >= 5) begin
            tick();
            chk({tag, ":s4"}, 32'(bus.current_state), 32'(s4));
        end
        tick();
        exp_cnt = (exp_cnt + 1) % 16;
        chk({tag, ":end"}, 32'(bus.current_state), 0);
        chk({tag, ":cnt"}, 32'(bus.inst_count), 32'(exp_cnt));
        chk({tag, ":ill"}, 32'(bus.illegal), 0);
    endtask

    initial begin
        bus.pause  = 1'b0;
        bus.opcode = 6'd0;
        do_reset();
        chk("rst_state", 32'(bus.current_state), 0);
        chk("rst_ill", 32'(bus.illegal), 0);
        chk("rst_cnt", 32'(bus.inst_count), 0);

        run_instr("lw", 6'b100011, 5, 4'd2, 4'd3, 4'd4);

        // back-to-back group from a fresh reset: 14 cycles, four retirements
        do_reset();
        run_instr("sw", 6'b101011, 4, 4'd2, 4'd5, 4'd0);
        run_instr("rtype", 6'b000000, 4, 4'd6, 4'd7, 4'd0);
        run_instr("beq", 6'b000100, 3, 4'd8, 4'd0, 4'd0);
        run_instr("j", 6'b000010, 3, 4'd9, 4'd0, 4'd0);
        chk("grp_cnt4", 32'(bus.inst_count), 4);

        run_instr("lui", 6'b001111, 4, 4'd11, 4'd10, 4'd0);
        run_instr("ori", 6'b001101, 4, 4'd12, 4'd10, 4'd0);
        run_instr("addi", 6'b001000, 4, 4'd2, 4'd10, 4'd0);
        run_instr("andi", 6'b001100, 4, 4'd12, 4'd10, 4'd0);

        // pause in MEMRD with a changed opcode
        bus.opcode = 6'b100011;
        tick();
        tick();
        tick();
        chk("pz_memrd", 32'(bus.current_state), 3);
        bus.pause  = 1'b1;
        bus.opcode = 6'b101011;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pz_hold", 32'(bus.current_state), 3);
            chk("pz_cnt", 32'(bus.inst_count), 32'(exp_cnt));
        end
        bus.pause = 1'b0;
        tick();
        chk("pz_memwb", 32'(bus.current_state), 4);
        tick();
        exp_cnt = (exp_cnt + 1) % 16;
        chk("pz_fetch", 32'(bus.current_state), 0);
        chk("pz_cnt_inc", 32'(bus.inst_count), 32'(exp_cnt));

        // pause in FETCH holds too
        bus.pause = 1'b1;
        tick();
        chk("pz_fetch_hold", 32'(bus.current_state), 0);
        bus.pause = 1'b0;

        // unsupported opcode
        bus.opcode = 6'b111111;
        tick();
        chk("ill_decode", 32'(bus.current_state), 1);
        tick();
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            bus.pause = i[0];
            chk("ill_halt", 32'(bus.current_state), 13);
            chk("ill_flag", 32'(bus.illegal), 1);
            chk("ill_cnt", 32'(bus.inst_count), 32'(exp_cnt));
            tick();
        end
        bus.pause = 1'b0;
        do_reset();
        chk("ill_rst_state", 32'(bus.current_state), 0);
        chk("ill_rst_flag", 32'(bus.illegal), 0);
`else
        chk("ill_fetch", 32'(bus.current_state), 0);
        chk("ill_flag", 32'(bus.illegal), 0);
        chk("ill_cnt", 32'(bus.inst_count), 32'(exp_cnt));
        do_reset();
`endif

        // wrap: 15 jumps reach all-ones, one more wraps to zero
        for (int i = 0; i < 15; i++) run_instr("wrap_j", 6'b000010, 3, 4'd9, 4'd0, 4'd0);
        chk("wrap_ones", 32'(bus.inst_count), 15);
        run_instr("wrap_beq", 6'b000100, 3, 4'd8, 4'd0, 4'd0);
        chk("wrap_zero", 32'(bus.inst_count), 0);
        run_instr("post_wrap", 6'b000010, 3, 4'd9, 4'd0, 4'd0);

        // async reset mid-instruction, checked before the next clock edge
        bus.opcode = 6'b100011;
        tick();
        tick();
        chk("ar_memadr", 32'(bus.current_state), 2);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_state", 32'(bus.current_state), 0);
        chk("ar_cnt", 32'(bus.inst_count), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        run_instr("ar_lw", 6'b100011, 5, 4'd2, 4'd3, 4'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_state_fsm.md
CPU_STATE_FSM -- requirements
Module: cpu_state_fsm

Interface
REQ-001 Parameter: CNT_W, default 16, width of the retired-instruction counter.
REQ-002 Port: clk  in  1  single clock; every register updates on the rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Port: pause  in  1  stall; while high, no register changes except through reset.
REQ-005 Port: opcode  in  6  instruction opcode from the instruction register (IR); valid from DECODE onward.
REQ-006 Port: current_state  out  4  registered state code, fed to the downstream control decoder.
REQ-007 Port: illegal  out  1  registered flag for an unsupported opcode.
REQ-008 Port: inst_count  out  CNT_W  registered count of instructions completed.

Function
REQ-009 State codes SHALL be:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 REX, 7 RWB
  - 8 BEQ, 9 JUMP, 10 IMMWB, 11 LUIEX, 12 LOGEX, 13 HALT
  - 14-15 unused.
REQ-010 When pause=1, the block SHALL hold current_state, op_q, illegal and inst_count unchanged.
REQ-011 When pause=0, FETCH SHALL go to DECODE.
REQ-012 In DECODE with pause=0, the block SHALL latch opcode into internal op_q.
REQ-013 In DECODE with pause=0, the next state SHALL be selected by opcode:
  - 100011 (lw), 101011 (sw), 001000 (addi) -> MEMADR
  - 000000 -> REX
  - 000100 -> BEQ
  - 000010 -> JUMP
  - 001111 -> LUIEX
  - 001100, 001101 -> LOGEX
  - any other opcode -> illegal handling per REQ-024/025.
REQ-014 MEMADR SHALL go to MEMRD if op_q=lw, MEMWR if op_q=sw, IMMWB if op_q=addi.
REQ-015 Fixed transitions: MEMRD->MEMWB, REX->RWB, LUIEX->IMMWB, LOGEX->IMMWB.
REQ-016 MEMWB, MEMWR, RWB, IMMWB, BEQ and JUMP SHALL each go to FETCH.
REQ-017 Each transition SHALL take exactly one unpaused cycle; the DECODE branch uses the opcode input combinationally, all later branches use op_q.
REQ-018 Instruction latency SHALL be:
  - lw 5 cycles
  - sw, R-type, addi, lui, andi, ori 4 cycles
  - beq, j 3 cycles.
REQ-019 inst_count SHALL increment by 1 on each unpaused transition into FETCH from MEMWB, MEMWR, RWB, IMMWB, BEQ or JUMP.
REQ-020 inst_count SHALL wrap from all-ones to 0 without any flag.
REQ-021 States 14-15, if reached, SHALL go to FETCH on the next unpaused cycle and SHALL NOT increment inst_count.
REQ-022 If rst rises mid-instruction, all outputs SHALL clear immediately; the partial instruction is not counted.

Reset
REQ-023 While rst=1, asynchronously: current_state=0 (FETCH), op_q=0, illegal=0, inst_count=0; after release, execution SHALL begin with FETCH on the first unpaused edge.

Configuration
REQ-024 With macro ILLEGAL_TRAP_EN defined, an unsupported opcode in DECODE (pause=0) SHALL:
  - set illegal=1 and move to HALT
  - keep HALT and illegal=1 until reset; pause has no effect on this
  - not increment inst_count.
REQ-025 Without ILLEGAL_TRAP_EN:
  - an unsupported opcode in DECODE SHALL return to FETCH and SHALL NOT increment inst_count
  - illegal SHALL be constant 0
  - HALT SHALL be unreachable; if entered, it SHALL behave like states 14-15.

Verification
REQ-026 Reset then lw (100011), pause=0 -> current_state sequence 0,1,2,3,4,0; inst_count 0->1 on the edge into 0.
REQ-027 sw, then R-type, then beq, then j, back-to-back -> sequences 0,1,2,5 / 0,1,6,7 / 0,1,8 / 0,1,9; inst_count=4 after 14 cycles.
REQ-028 lui, then ori, then addi -> sequences 0,1,11,10 / 0,1,12,10 / 0,1,2,10; each increments inst_count.
REQ-029 pause=1 for 3 cycles while in state 3 -> state remains 3 for those 3 cycles, then 4; opcode changed during the pause does not alter the path.
REQ-030 Opcode 111111 in DECODE -> with ILLEGAL_TRAP_EN: state 13 and illegal=1 held for 10 cycles until rst; without the macro: state 0, illegal=0, inst_count unchanged.
REQ-031 Preload inst_count to all-ones (CNT_W=4, 15 instructions), complete one more -> inst_count=0; assert rst asynchronously in state 2 -> state=0 before the next clk edge.
